implication_queue: RTL



---
 rtl/implication_queue.sv | 112 +++++++++++
 1 files changed

// File: rtl/implication_queue.sv
// BCP implication queue: circular buffer with valid/ready push/pop ports.
// Define IMPL_DEDUP_EN to build the duplicate/conflict comparators and the sticky CONFLICT state.
module implication_queue #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned MAX_VARS_BITS = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [MAX_VARS_BITS-1:0] in_var,
    input  logic                     in_val,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [MAX_VARS_BITS-1:0] out_var,
    output logic                     out_val,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     conflict,
    output logic [MAX_VARS_BITS-1:0] conflict_var
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {RUN, CONFLICT} state_t;

    state_t                   state_q, state_d;
    logic [MAX_VARS_BITS-1:0] var_q [DEPTH];
    logic [DEPTH-1:0]         val_q;
    logic [AW-1:0]            head_q, head_d;
    logic [AW-1:0]            tail_q, tail_d;
    logic [AW:0]              count_q, count_d;
    logic [MAX_VARS_BITS-1:0] cvar_q, cvar_d;

    logic push, pop, store, hit_same, hit_opp;

    // An entry is occupied when its distance from head is below count; the head counts even if popped now.
    always_comb begin
        hit_same = 1'b0;
        hit_opp  = 1'b0;
`ifdef IMPL_DEDUP_EN
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (({1'b0, AW'(i) - head_q} < count_q) && (var_q[i] == in_var)) begin
                if (val_q[i] == in_val) hit_same = 1'b1;
                else                    hit_opp  = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        in_ready  = (count_q != FULL) && (state_q == RUN);
        out_valid = (count_q != '0) && (state_q == RUN);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        store     = push & ~hit_same & ~hit_opp;

        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        cvar_d  = cvar_q;

        if (flush) begin
            state_d = RUN;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            cvar_d  = '0;
        end else begin
            if (pop)   head_d = head_q + 1'b1;
            if (store) tail_d = tail_q + 1'b1;
            count_d = count_q + (AW+1)'(store) - (AW+1)'(pop);
            if (push && hit_opp) begin
                state_d = CONFLICT;
                cvar_d  = in_var;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cvar_q  <= '0;
            val_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                var_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cvar_q  <= cvar_d;
            if (store && !flush) begin
                var_q[tail_q] <= in_var;
                val_q[tail_q] <= in_val;
            end
        end
    end

    assign out_var      = var_q[head_q];
    assign out_val      = val_q[head_q];
    assign count        = count_q;
    assign conflict     = (state_q == CONFLICT);
    assign conflict_var = cvar_q;

endmodule
